// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the single-step clock controller: mode encodings
// and default timing parameters.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HALT  = 2'b00,
    MODE_RUN   = 2'b01,
    MODE_BREAK = 2'b10
  } mode_e;

  localparam int DEF_DIV_SLOW = 50_000_000;
  localparam int DEF_DIV_FAST = 100_000;
  localparam int DEF_DB_CYC   = 1_000_000;

  // Counter width able to hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/step_clk_ctrl_debouncer.sv
// Push-button debouncer: the output follows the input only after the input
// has disagreed with it for DB_CYC consecutive cycles.
module debouncer
  import step_ctrl_pkg::*;
#(
  parameter int DB_CYC = DEF_DB_CYC
) (
  input  logic Clk,
  input  logic Reset,
  input  logic In,
  output logic Out
);

  localparam int CW = cnt_width(DB_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;

  always_comb begin
    cnt_d = '0;
    out_d = out_q;
    if (In != out_q) begin
      if (cnt_q == CW'(DB_CYC - 1)) begin
        out_d = ~out_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= out_d;
    end
  end

  assign Out = out_q;

endmodule

// File: rtl/step_clk_ctrl.sv
// Processor clock-enable generator: halt / free-run / breakpoint modes with
// debounced single-step button; replaces the free-running divider.
module step_clk_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DIV_SLOW = DEF_DIV_SLOW,
  parameter int DIV_FAST = DEF_DIV_FAST,
  parameter int DB_CYC   = DEF_DB_CYC
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        BtnStep,
  input  logic        SwRun,
  input  logic        SwFast,
  input  logic        BrkEn,
  input  logic [31:0] BrkPC,
  input  logic [31:0] PC,
  output logic        ProcEn,
  output logic [1:0]  Mode,
  output logic [15:0] CycleCount
);

  localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int TW      = cnt_width(DIV_MAX);

  // Bit order: 0 = BtnStep, 1 = SwRun, 2 = SwFast
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {SwFast, SwRun, BtnStep};
      sync2_q <= sync1_q;
    end
  end

  logic btn_s, run_s, fast_s;
  assign btn_s  = sync2_q[0];
  assign run_s  = sync2_q[1];
  assign fast_s = sync2_q[2];

  logic btn_db, btn_db_prev_q, step_req;

  debouncer #(.DB_CYC(DB_CYC)) u_btn_db (
    .Clk   (Clk),
    .Reset (Reset),
    .In    (btn_s),
    .Out   (btn_db)
  );

  assign step_req = btn_db & ~btn_db_prev_q;

  logic [TW-1:0] tick_q, tick_d, div_m1;
  logic          fast_prev_q, fast_chg, tick, tick_clr;

  assign div_m1   = fast_s ? TW'(DIV_FAST - 1) : TW'(DIV_SLOW - 1);
  assign fast_chg = fast_s ^ fast_prev_q;
  // A rate change restarts the period, so no tick may fire on the stale count.
  assign tick     = ~fast_chg && (tick_q == div_m1);

  always_comb begin
    tick_d = tick_q + 1'b1;
    if (fast_chg || tick_clr || tick) begin
      tick_d = '0;
    end
  end

  mode_e state_q, state_d;
  logic  proc_en_q, proc_en_d;
  logic  pc_hit;
  logic [15:0] cycle_q;

  assign pc_hit = BrkEn && (PC == BrkPC);

  always_comb begin
    state_d   = state_q;
    proc_en_d = 1'b0;
    tick_clr  = 1'b0;
    unique case (state_q)
      MODE_HALT: begin
        if (run_s) begin
          state_d  = MODE_RUN;
          tick_clr = 1'b1;
        end else if (step_req) begin
          proc_en_d = 1'b1;
        end
      end
      MODE_RUN: begin
        if (!run_s) begin
          state_d = MODE_HALT;
        end else if (tick && !proc_en_q) begin
          if (pc_hit) begin
            state_d = MODE_BREAK;
          end else begin
            proc_en_d = 1'b1;
          end
        end
      end
      MODE_BREAK: begin
        if (!run_s) begin
          state_d = MODE_HALT;
        end else if (step_req) begin
          proc_en_d = 1'b1;
          state_d   = MODE_RUN;
        end
      end
      default: state_d = MODE_HALT;
    endcase
    // Guarantees a single-cycle pulse even when a step is followed by a tick.
    if (proc_en_q) begin
      proc_en_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= MODE_HALT;
      proc_en_q     <= 1'b0;
      cycle_q       <= '0;
      tick_q        <= '0;
      fast_prev_q   <= 1'b0;
      btn_db_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      proc_en_q     <= proc_en_d;
      cycle_q       <= cycle_q + 16'(proc_en_q);
      tick_q        <= tick_d;
      fast_prev_q   <= fast_s;
      btn_db_prev_q <= btn_db;
    end
  end

  assign ProcEn     = proc_en_q;
  assign Mode       = state_q;
  assign CycleCount = cycle_q;

endmodule

// File: tb/tb_step_clk_ctrl.sv
// Directed self-checking bench for step_clk_ctrl with short timing parameters.
module tb_step_clk_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_step = 1'b0, sw_run = 1'b0, sw_fast = 1'b0, brk_en = 1'b0;
  logic [31:0] brk_pc = 32'h0;
  logic [31:0] pc;
  logic        proc_en;
  logic [1:0]  mode;
  logic [15:0] cycle_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int consec = 0;
  int pc_base = 0;
  int pulse_time [1024];
  logic prev_en = 1'b0;

  always #5 clk = ~clk;

  assign pc = 32'(4 * (pulse_cnt - pc_base));

  step_clk_ctrl #(.DIV_SLOW(8), .DIV_FAST(2), .DB_CYC(4)) dut (
    .Clk        (clk),
    .Reset      (reset),
    .BtnStep    (btn_step),
    .SwRun      (sw_run),
    .SwFast     (sw_fast),
    .BrkEn      (brk_en),
    .BrkPC      (brk_pc),
    .PC         (pc),
    .ProcEn     (proc_en),
    .Mode       (mode),
    .CycleCount (cycle_count)
  );

  always @(posedge clk) begin
    #1;
    cyc++;
    if (proc_en) begin
      if (prev_en) consec++;
      pulse_cnt++;
      pulse_time[pulse_cnt % 1024] = cyc;
    end
    prev_en = proc_en;
  end

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for a ProcEn pulse at negedges; n = edges elapsed, found = 0 on timeout.
  task automatic wait_en(input int budget, output int n, output int found);
    found = 0;
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (proc_en) begin
        n = i;
        found = 1;
        break;
      end
    end
  endtask

  task automatic check_gaps(input string tag, input int first, input int last, input int gap);
    for (int k = first + 1; k <= last; k++) begin
      chk(tag, pulse_time[k % 1024] - pulse_time[(k - 1) % 1024], gap);
    end
  endtask

  initial begin
    int n, found, s0, e0, pb;

    // Reset and idle
    cycles(3);
    reset = 1'b0;
    chk("rst_procen", int'(proc_en), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_count", int'(cycle_count), 0);
    cycles(100);
    chk("idle_pulses", pulse_cnt, 0);
    chk("idle_mode", int'(mode), 0);
    chk("idle_count", int'(cycle_count), 0);

    // Bouncing button then a clean hold
    btn_step = 1'b1; cycles(1);
    btn_step = 1'b0; cycles(1);
    btn_step = 1'b1; cycles(1);
    btn_step = 1'b0; cycles(1);
    btn_step = 1'b1; cycles(10);
    btn_step = 1'b0; cycles(12);
    chk("bounce_pulses", pulse_cnt, 1);
    chk("bounce_count", int'(cycle_count), 1);
    chk("bounce_mode", int'(mode), 0);

    // Free-run slow, then fast
    sw_run = 1'b1;
    s0 = pulse_cnt;
    cycles(80);
    e0 = pulse_cnt;
    chk("slow_enough", int'((e0 - s0) >= 8), 1);
    chk("slow_mode", int'(mode), 1);
    check_gaps("slow_gap", s0 + 1, e0, 8);
    sw_fast = 1'b1;
    cycles(6);
    s0 = pulse_cnt;
    cycles(20);
    e0 = pulse_cnt;
    chk("fast_enough", int'((e0 - s0) >= 8), 1);
    check_gaps("fast_gap", s0 + 1, e0, 2);

    // Halt arriving in the same cycle as a tick
    sw_fast = 1'b0;
    cycles(12);
    wait_en(20, n, found);
    chk("hw_pulse_seen", found, 1);
    pb = pulse_cnt;
    repeat (5) @(posedge clk);
    @(negedge clk);
    sw_run = 1'b0;
    cycles(2);
    chk("hw_mode_before", int'(mode), 1);
    cycles(1);
    chk("hw_procen", int'(proc_en), 0);
    chk("hw_mode_after", int'(mode), 0);
    cycles(20);
    chk("hw_no_pulse", pulse_cnt - pb, 0);

    // Breakpoint at 0x0C
    pc_base = pulse_cnt;
    brk_en = 1'b1;
    brk_pc = 32'h0000_000C;
    pb = pulse_cnt;
    sw_run = 1'b1;
    cycles(60);
    chk("brk_pulses", pulse_cnt - pb, 3);
    chk("brk_mode", int'(mode), 2);
    cycles(30);
    chk("brk_hold", pulse_cnt - pb, 3);
    btn_step = 1'b1;
    wait_en(20, n, found);
    chk("brk_step_seen", found, 1);
    chk("brk_step_mode", int'(mode), 1);
    chk("brk_step_pulses", pulse_cnt - pb, 4);
    btn_step = 1'b0;
    sw_run = 1'b0;
    brk_en = 1'b0;
    cycles(15);

    // Reset mid-run with CycleCount = 5
    reset = 1'b1;
    sw_run = 1'b1;
    sw_fast = 1'b1;
    cycles(3);
    reset = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cycle_count == 16'd5) begin
        found = 1;
        break;
      end
    end
    chk("mid_reached5", found, 1);
    chk("mid_mode_run", int'(mode), 1);
    reset = 1'b1;
    cycles(1);
    chk("mid_procen", int'(proc_en), 0);
    chk("mid_count", int'(cycle_count), 0);
    chk("mid_mode", int'(mode), 0);

    // Button held through reset release
    sw_run = 1'b0;
    sw_fast = 1'b0;
    btn_step = 1'b1;
    cycles(3);
    pb = pulse_cnt;
    reset = 1'b0;
    wait_en(20, n, found);
    chk("held_seen", found, 1);
    chk("held_latency", n, 7);
    cycles(10);
    btn_step = 1'b0;
    cycles(10);
    chk("held_once", pulse_cnt - pb, 1);
    chk("held_count", int'(cycle_count), 1);

    chk("no_back_to_back", consec, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
